// File: rtl/rah_tx_scheduler_pkg.sv
// Shared definitions for the RAH transmit scheduler.
// Contents:
//   RAH_PACKET_WIDTH  default RAH packet word width
//   APP_VERSION/USER  application index assignments (app 0 = version responder)
//   state_e           scheduler FSM state encoding (IDLE=0, XFER=1)
//   app_id_width()    width of an app id field (minimum 1 bit)
package rah_tx_scheduler_pkg;

  localparam int RAH_PACKET_WIDTH = 48;

  localparam int APP_VERSION = 0;
  localparam int APP_USER    = 1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_XFER = 1'b1
  } state_e;

  // A single app still needs a 1-bit id field, so clamp $clog2 from below.
  function automatic int app_id_width(input int n);
    if (n <= 2) begin
      return 1;
    end else begin
      return $clog2(n);
    end
  endfunction

endpackage

// File: rtl/rah_tx_scheduler_pick.sv
// Round-robin priority picker (combinational).
// Selects the first requesting index strictly after rr_ptr_i, scanning
// upward and wrapping from N-1 to 0. rr_ptr_i itself has lowest priority.
// Ports:
//   req_i     [N-1:0]      per-app request
//   rr_ptr_i  [IDX_W-1:0]  index of the last granted app
//   pick_o    [N-1:0]      one-hot winner (all zero when no request)
//   idx_o     [IDX_W-1:0]  binary index of the winner
module rr_priority_pick #(
  parameter int N     = 2,
  parameter int IDX_W = 1
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] rr_ptr_i,
  output logic [N-1:0]     pick_o,
  output logic [IDX_W-1:0] idx_o
);

  logic [IDX_W-1:0] cand_s;
  logic             found_s;

  // Scan offsets 1..N from the pointer; the first hit wins.
  always_comb begin
    pick_o  = '0;
    idx_o   = '0;
    found_s = 1'b0;
    cand_s  = '0;
    for (int k = 1; k <= N; k++) begin
      cand_s = IDX_W'((int'(rr_ptr_i) + k) % N);
      if (!found_s && req_i[cand_s]) begin
        found_s        = 1'b1;
        pick_o[cand_s] = 1'b1;
        idx_o          = cand_s;
      end else begin
        found_s = found_s;
      end
    end
  end

endmodule

// File: rtl/rah_tx_scheduler.sv
// Round-robin packet scheduler sharing the RAH transmit write port.
// One app is granted per packet; its words are forwarded with a 1-cycle
// registered latency, tagged with the app id and end-of-packet flag.
// Packets reaching MAX_LEN words without a last flag are truncated and
// flagged in the sticky err_overlen vector.
// Ports:
//   clk, rst         clock and synchronous active-high reset
//   req/req_data/req_last  per-app word valid, packed words, last flag
//   ack              one-hot: word of that app is consumed this cycle
//   wr_almost_full   downstream FIFO has at most one free slot
//   out_valid/out_data/out_app_id/out_last  registered FIFO write side
//   busy             high while a packet grant is held (state XFER)
//   err_overlen      sticky per-app over-length flag
//   err_clear        clears err_overlen (wins over a same-cycle set)
module rah_tx_scheduler
  import rah_tx_scheduler_pkg::*;
#(
  parameter int TOTAL_APPS = 2,
  parameter int DATA_WIDTH = RAH_PACKET_WIDTH,
  parameter int MAX_LEN    = 64,
  parameter int APP_ID_W   = app_id_width(TOTAL_APPS)
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [TOTAL_APPS-1:0]            req,
  input  logic [TOTAL_APPS*DATA_WIDTH-1:0] req_data,
  input  logic [TOTAL_APPS-1:0]            req_last,
  output logic [TOTAL_APPS-1:0]            ack,
  input  logic                             wr_almost_full,
  output logic                             out_valid,
  output logic [DATA_WIDTH-1:0]            out_data,
  output logic [APP_ID_W-1:0]              out_app_id,
  output logic                             out_last,
  output logic                             busy,
  output logic [TOTAL_APPS-1:0]            err_overlen,
  input  logic                             err_clear
);

  localparam int              CNT_W    = $clog2(MAX_LEN);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAX_LEN - 1);

  state_e                  state_q, state_d;
  logic [APP_ID_W-1:0]     grant_q, grant_d;
  logic [APP_ID_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]        word_cnt_q, word_cnt_d;
  logic                    out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0]   out_data_q, out_data_d;
  logic [APP_ID_W-1:0]     out_app_id_q, out_app_id_d;
  logic                    out_last_q, out_last_d;
  logic [TOTAL_APPS-1:0]   err_q, err_d;

  logic [TOTAL_APPS-1:0]   pick_s;
  logic [APP_ID_W-1:0]     pick_idx_s;
  logic                    any_s;
  logic                    sel_req_s;
  logic                    sel_last_s;
  logic [DATA_WIDTH-1:0]   sel_data_s;
  logic [TOTAL_APPS-1:0]   grant_oh_s;
  logic                    accept_s;
  logic                    force_s;
  logic [TOTAL_APPS-1:0]   err_set_s;

  rr_priority_pick #(
    .N     (TOTAL_APPS),
    .IDX_W (APP_ID_W)
  ) u_pick (
    .req_i    (req),
    .rr_ptr_i (rr_ptr_q),
    .pick_o   (pick_s),
    .idx_o    (pick_idx_s)
  );

  assign any_s = |pick_s;

  // Mux the granted app's request, last flag and word (constant-index loop).
  always_comb begin
    sel_req_s  = 1'b0;
    sel_last_s = 1'b0;
    sel_data_s = '0;
    grant_oh_s = '0;
    for (int i = 0; i < TOTAL_APPS; i++) begin
      if (grant_q == APP_ID_W'(i)) begin
        sel_req_s     = req[i];
        sel_last_s    = req_last[i];
        sel_data_s    = req_data[i*DATA_WIDTH +: DATA_WIDTH];
        grant_oh_s[i] = 1'b1;
      end else begin
        grant_oh_s[i] = 1'b0;
      end
    end
  end

  assign accept_s = (state_q == ST_XFER) && sel_req_s && !wr_almost_full;
  // Final permitted slot reached without the sender marking last: truncate.
  assign force_s  = (word_cnt_q == LAST_CNT) && !sel_last_s;

  // FSM next state, grant/pointer/counter updates and error set pulses.
  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    rr_ptr_d   = rr_ptr_q;
    word_cnt_d = word_cnt_q;
    err_set_s  = '0;
    case (state_q)
      ST_IDLE: begin
        if (any_s) begin
          grant_d    = pick_idx_s;
          word_cnt_d = '0;
          state_d    = ST_XFER;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_XFER: begin
        if (accept_s && (sel_last_s || force_s)) begin
          state_d   = ST_IDLE;
          rr_ptr_d  = grant_q;
          err_set_s = force_s ? grant_oh_s : '0;
        end else if (accept_s) begin
          word_cnt_d = word_cnt_q + CNT_W'(1);
        end else begin
          state_d = ST_XFER;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output register next values; payload holds when nothing is accepted.
  always_comb begin
    out_valid_d  = accept_s;
    out_data_d   = out_data_q;
    out_app_id_d = out_app_id_q;
    out_last_d   = out_last_q;
    if (accept_s) begin
      out_data_d   = sel_data_s;
      out_app_id_d = grant_q;
      out_last_d   = sel_last_s || force_s;
    end else begin
      out_valid_d = 1'b0;
    end
    if (err_clear) begin
      err_d = '0;
    end else begin
      err_d = err_q | err_set_s;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      grant_q      <= '0;
      rr_ptr_q     <= APP_ID_W'(TOTAL_APPS - 1);
      word_cnt_q   <= '0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_app_id_q <= '0;
      out_last_q   <= 1'b0;
      err_q        <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      rr_ptr_q     <= rr_ptr_d;
      word_cnt_q   <= word_cnt_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_app_id_q <= out_app_id_d;
      out_last_q   <= out_last_d;
      err_q        <= err_d;
    end
  end

  assign ack         = accept_s ? grant_oh_s : '0;
  assign out_valid   = out_valid_q;
  assign out_data    = out_data_q;
  assign out_app_id  = out_app_id_q;
  assign out_last    = out_last_q;
  assign busy        = (state_q == ST_XFER);
  assign err_overlen = err_q;

endmodule

// File: tb/tb_rah_tx_scheduler.sv
// Directed bench for rah_tx_scheduler with 3 apps and MAX_LEN=4.
module tb_rah_tx_scheduler;

  localparam int TA = 3;
  localparam int DW = 48;
  localparam int ML = 4;
  localparam int AW = 2;

  logic             clk;
  logic             rst;
  logic [TA-1:0]    req;
  logic [TA*DW-1:0] req_data;
  logic [TA-1:0]    req_last;
  logic [TA-1:0]    ack;
  logic             wr_almost_full;
  logic             out_valid;
  logic [DW-1:0]    out_data;
  logic [AW-1:0]    out_app_id;
  logic             out_last;
  logic             busy;
  logic [TA-1:0]    err_overlen;
  logic             err_clear;

  int n_tests;
  int n_fail;

  // sender word queues
  logic [DW-1:0] wq [TA][32];
  logic          lq [TA][32];
  int            head [TA];
  int            tail [TA];

  // per-cycle record and output log
  logic [TA-1:0] ack_seen;
  logic [TA-1:0] cyc_ack  [32];
  logic          cyc_ov   [32];
  logic          cyc_busy [32];
  int            cidx;
  logic [DW-1:0] lg_data [64];
  logic [AW-1:0] lg_app  [64];
  logic          lg_last [64];
  int            lg_n;

  rah_tx_scheduler #(
    .TOTAL_APPS (TA),
    .DATA_WIDTH (DW),
    .MAX_LEN    (ML),
    .APP_ID_W   (AW)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .req            (req),
    .req_data       (req_data),
    .req_last       (req_last),
    .ack            (ack),
    .wr_almost_full (wr_almost_full),
    .out_valid      (out_valid),
    .out_data       (out_data),
    .out_app_id     (out_app_id),
    .out_last       (out_last),
    .busy           (busy),
    .err_overlen    (err_overlen),
    .err_clear      (err_clear)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [DW-1:0] mkw(input int a, input int s);
    return {8'hA0 + 8'(a), 8'h5C, 32'(s)};
  endfunction

  task automatic push_pkt(input int a, input int n, input bit with_last, input int seq0);
    for (int k = 0; k < n; k++) begin
      wq[a][tail[a]] = mkw(a, seq0 + k);
      lq[a][tail[a]] = with_last && (k == n - 1);
      tail[a]++;
    end
  endtask

  task automatic clear_q(input int a);
    head[a] = 0;
    tail[a] = 0;
  endtask

  task automatic start_log();
    cidx = 0;
    lg_n = 0;
  endtask

  // One clock: drive queue heads, sample ack before the edge, log after it.
  task automatic cycle();
    for (int i = 0; i < TA; i++) begin
      if (head[i] < tail[i]) begin
        req[i]               = 1'b1;
        req_data[i*DW +: DW] = wq[i][head[i]];
        req_last[i]          = lq[i][head[i]];
      end else begin
        req[i]               = 1'b0;
        req_data[i*DW +: DW] = '0;
        req_last[i]          = 1'b0;
      end
    end
    @(negedge clk);
    ack_seen = ack;
    @(posedge clk);
    #1;
    for (int i = 0; i < TA; i++) begin
      if (ack_seen[i]) head[i]++;
    end
    if (out_valid && lg_n < 64) begin
      lg_data[lg_n] = out_data;
      lg_app[lg_n]  = out_app_id;
      lg_last[lg_n] = out_last;
      lg_n++;
    end
    if (cidx < 32) begin
      cyc_ack[cidx]  = ack_seen;
      cyc_ov[cidx]   = out_valid;
      cyc_busy[cidx] = busy;
      cidx++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cycle();
    cycle();
    n_tests++;
    if ({out_valid, out_data, out_app_id, out_last} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs got v=%0b d=%h id=%0d l=%0b exp all 0", out_valid, out_data, out_app_id, out_last);
    end
    n_tests++;
    if ({busy, err_overlen, ack} !== '0) begin
      n_fail++;
      $display("FAIL reset_status got busy=%0b err=%b ack=%b exp all 0", busy, err_overlen, ack);
    end
    rst = 1'b0;
  endtask

  task automatic test_single();
    logic [TA-1:0] exp_ack [5] = '{3'd0, 3'd2, 3'd2, 3'd2, 3'd0};
    logic          exp_ov  [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    logic          exp_bz  [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    start_log();
    push_pkt(1, 3, 1'b1, 1);
    repeat (5) cycle();
    for (int c = 0; c < 5; c++) begin
      n_tests++;
      if (cyc_ack[c] !== exp_ack[c] || cyc_ov[c] !== exp_ov[c] || cyc_busy[c] !== exp_bz[c]) begin
        n_fail++;
        $display("FAIL single_cycle%0d got ack=%b ov=%0b busy=%0b exp ack=%b ov=%0b busy=%0b",
                 c + 1, cyc_ack[c], cyc_ov[c], cyc_busy[c], exp_ack[c], exp_ov[c], exp_bz[c]);
      end
    end
    n_tests++;
    if (lg_n !== 3) begin
      n_fail++;
      $display("FAIL single_count got %0d exp 3", lg_n);
    end
    for (int k = 0; k < 3 && k < lg_n; k++) begin
      n_tests++;
      if (lg_data[k] !== mkw(1, k + 1) || lg_app[k] !== 2'd1 || lg_last[k] !== (k == 2)) begin
        n_fail++;
        $display("FAIL single_word%0d got d=%h id=%0d l=%0b exp d=%h id=1 l=%0b",
                 k, lg_data[k], lg_app[k], lg_last[k], mkw(1, k + 1), (k == 2));
      end
    end
  endtask

  task automatic test_round_robin();
    int exp_app [8] = '{0, 0, 1, 1, 0, 0, 1, 1};
    int exp_seq [8] = '{1, 2, 1, 2, 3, 4, 3, 4};
    start_log();
    push_pkt(0, 2, 1'b1, 1);
    push_pkt(0, 2, 1'b1, 3);
    push_pkt(1, 2, 1'b1, 1);
    push_pkt(1, 2, 1'b1, 3);
    repeat (12) cycle();
    for (int c = 0; c < 12; c++) begin
      n_tests++;
      if (cyc_ov[c] !== ((c + 1) % 3 != 1)) begin
        n_fail++;
        $display("FAIL rr_gap_cycle%0d got ov=%0b exp %0b", c + 1, cyc_ov[c], ((c + 1) % 3 != 1));
      end
    end
    n_tests++;
    if (lg_n !== 8) begin
      n_fail++;
      $display("FAIL rr_count got %0d exp 8", lg_n);
    end
    for (int k = 0; k < 8 && k < lg_n; k++) begin
      n_tests++;
      if (lg_data[k] !== mkw(exp_app[k], exp_seq[k]) || lg_app[k] !== AW'(exp_app[k]) || lg_last[k] !== (k % 2 == 1)) begin
        n_fail++;
        $display("FAIL rr_word%0d got d=%h id=%0d l=%0b exp d=%h id=%0d l=%0b",
                 k, lg_data[k], lg_app[k], lg_last[k], mkw(exp_app[k], exp_seq[k]), exp_app[k], (k % 2 == 1));
      end
    end
  endtask

  task automatic test_back_pressure();
    logic [TA-1:0] exp_ack [11] = '{3'd0, 3'd2, 3'd2, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd2, 3'd2, 3'd0};
    logic          exp_ov  [11] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    start_log();
    push_pkt(1, 4, 1'b1, 1);
    for (int c = 1; c <= 11; c++) begin
      wr_almost_full = (c >= 4 && c <= 8);
      cycle();
    end
    wr_almost_full = 1'b0;
    for (int c = 0; c < 11; c++) begin
      n_tests++;
      if (cyc_ack[c] !== exp_ack[c] || cyc_ov[c] !== exp_ov[c]) begin
        n_fail++;
        $display("FAIL bp_cycle%0d got ack=%b ov=%0b exp ack=%b ov=%0b",
                 c + 1, cyc_ack[c], cyc_ov[c], exp_ack[c], exp_ov[c]);
      end
    end
    n_tests++;
    if (lg_n !== 4) begin
      n_fail++;
      $display("FAIL bp_count got %0d exp 4", lg_n);
    end
    for (int k = 0; k < 4 && k < lg_n; k++) begin
      n_tests++;
      if (lg_data[k] !== mkw(1, k + 1) || lg_last[k] !== (k == 3)) begin
        n_fail++;
        $display("FAIL bp_word%0d got d=%h l=%0b exp d=%h l=%0b", k, lg_data[k], lg_last[k], mkw(1, k + 1), (k == 3));
      end
    end
  endtask

  task automatic test_overlen();
    start_log();
    push_pkt(1, 6, 1'b0, 1);
    repeat (5) cycle();
    clear_q(1);
    n_tests++;
    if (lg_n !== 4) begin
      n_fail++;
      $display("FAIL ovl_count got %0d exp 4", lg_n);
    end
    for (int k = 0; k < 4 && k < lg_n; k++) begin
      n_tests++;
      if (lg_data[k] !== mkw(1, k + 1) || lg_last[k] !== (k == 3)) begin
        n_fail++;
        $display("FAIL ovl_word%0d got d=%h l=%0b exp d=%h l=%0b", k, lg_data[k], lg_last[k], mkw(1, k + 1), (k == 3));
      end
    end
    n_tests++;
    if (err_overlen !== 3'b010 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL ovl_flag got err=%b busy=%0b exp err=010 busy=0", err_overlen, busy);
    end
    repeat (2) cycle();
    n_tests++;
    if (err_overlen !== 3'b010) begin
      n_fail++;
      $display("FAIL ovl_sticky got %b exp 010", err_overlen);
    end
    err_clear = 1'b1;
    cycle();
    err_clear = 1'b0;
    n_tests++;
    if (err_overlen !== 3'b000) begin
      n_fail++;
      $display("FAIL ovl_clear got %b exp 000", err_overlen);
    end
    // exactly MAX_LEN words ending in last is legal
    start_log();
    push_pkt(0, 4, 1'b1, 1);
    repeat (6) cycle();
    n_tests++;
    if (lg_n !== 4 || err_overlen !== 3'b000) begin
      n_fail++;
      $display("FAIL maxlen_ok got count=%0d err=%b exp count=4 err=000", lg_n, err_overlen);
    end
    for (int k = 0; k < 4 && k < lg_n; k++) begin
      n_tests++;
      if (lg_data[k] !== mkw(0, k + 1) || lg_app[k] !== 2'd0 || lg_last[k] !== (k == 3)) begin
        n_fail++;
        $display("FAIL maxlen_word%0d got d=%h id=%0d l=%0b exp d=%h id=0 l=%0b",
                 k, lg_data[k], lg_app[k], lg_last[k], mkw(0, k + 1), (k == 3));
      end
    end
  endtask

  task automatic test_reset_mid();
    start_log();
    push_pkt(1, 4, 1'b1, 1);
    repeat (3) cycle();
    n_tests++;
    if (out_valid !== 1'b1 || out_data !== mkw(1, 2)) begin
      n_fail++;
      $display("FAIL rstmid_pre got v=%0b d=%h exp v=1 d=%h", out_valid, out_data, mkw(1, 2));
    end
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    clear_q(1);
    n_tests++;
    if ({out_valid, out_data, out_app_id, out_last, busy, ack} !== '0) begin
      n_fail++;
      $display("FAIL rstmid_outputs got v=%0b d=%h id=%0d l=%0b busy=%0b ack=%b exp all 0",
               out_valid, out_data, out_app_id, out_last, busy, ack);
    end
  endtask

  task automatic test_ptr_wrap();
    int exp_app [4] = '{0, 0, 2, 2};
    start_log();
    push_pkt(0, 2, 1'b1, 1);
    push_pkt(2, 2, 1'b1, 1);
    repeat (7) cycle();
    n_tests++;
    if (lg_n !== 4) begin
      n_fail++;
      $display("FAIL wrap_count got %0d exp 4", lg_n);
    end
    for (int k = 0; k < 4 && k < lg_n; k++) begin
      n_tests++;
      if (lg_app[k] !== AW'(exp_app[k]) || lg_data[k] !== mkw(exp_app[k], (k % 2) + 1)) begin
        n_fail++;
        $display("FAIL wrap_word%0d got id=%0d d=%h exp id=%0d d=%h",
                 k, lg_app[k], lg_data[k], exp_app[k], mkw(exp_app[k], (k % 2) + 1));
      end
    end
  endtask

  task automatic test_resend();
    start_log();
    push_pkt(1, 4, 1'b1, 1);
    repeat (6) cycle();
    for (int c = 0; c < 6; c++) begin
      n_tests++;
      if (cyc_ack[c] !== ((c >= 1 && c <= 4) ? 3'd2 : 3'd0)) begin
        n_fail++;
        $display("FAIL resend_ack_cycle%0d got %b exp %b", c + 1, cyc_ack[c], ((c >= 1 && c <= 4) ? 3'd2 : 3'd0));
      end
    end
    n_tests++;
    if (lg_n !== 4) begin
      n_fail++;
      $display("FAIL resend_count got %0d exp 4", lg_n);
    end
    for (int k = 0; k < 4 && k < lg_n; k++) begin
      n_tests++;
      if (lg_data[k] !== mkw(1, k + 1) || lg_app[k] !== 2'd1 || lg_last[k] !== (k == 3)) begin
        n_fail++;
        $display("FAIL resend_word%0d got d=%h id=%0d l=%0b exp d=%h id=1 l=%0b",
                 k, lg_data[k], lg_app[k], lg_last[k], mkw(1, k + 1), (k == 3));
      end
    end
  endtask

  initial begin
    n_tests        = 0;
    n_fail         = 0;
    rst            = 1'b1;
    req            = '0;
    req_data       = '0;
    req_last       = '0;
    wr_almost_full = 1'b0;
    err_clear      = 1'b0;
    for (int i = 0; i < TA; i++) begin
      head[i] = 0;
      tail[i] = 0;
    end
    test_reset();
    test_single();
    test_round_robin();
    test_back_pressure();
    test_overlen();
    test_reset_mid();
    test_ptr_wrap();
    test_resend();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
